// File: rtl/fpu_pkg.sv
// ----------------------------------------------------------------------------
// fpu_pkg
// Shared definitions for the FPU add/subtract scheduler slice.
//   FP_WIDTH     : IEEE-754 double width (64)
//   NUM_PORTS    : number of requesters sharing the datapath (2)
//   FPU_OP_ADD/SUB : op encoding carried on req_op / dp_op
//   port_tag_t   : identifies the requester an operation belongs to
//   issue_t      : contents of the issue register feeding the datapath
// ----------------------------------------------------------------------------
package fpu_pkg;

   localparam int FP_WIDTH  = 64;
   localparam int NUM_PORTS = 2;

   localparam logic FPU_OP_ADD = 1'b0;
   localparam logic FPU_OP_SUB = 1'b1;

   typedef logic port_tag_t;

   typedef struct packed {
      logic                op;
      port_tag_t           tag;
      logic [FP_WIDTH-1:0] a;
      logic [FP_WIDTH-1:0] b;
   } issue_t;

   // Tag of a one-hot two-port grant vector.
   function automatic port_tag_t grant_to_tag(input logic [NUM_PORTS-1:0] grant);
      return port_tag_t'(grant[1]);
   endfunction

endpackage

// File: rtl/fpu_addsub_sched_if.sv
// ----------------------------------------------------------------------------
// fpu_addsub_sched_if
// Bundles the requester handshakes, the response path and the shared
// datapath connection of fpu_addsub_sched.
//   req_*   : per-port request (valid/ready, op, 64-bit operands packed per port)
//   resp_*  : per-port response (valid/ready, result, ovf/unf flags)
//   dp_*    : operands to and results from the shared add/sub datapath
//   exc_sticky / exc_clear : sticky exception flags, only present when
//                            FPU_SCHED_EXC_STICKY_EN is defined
// Modports:
//   slave  : the scheduler's view
//   master : the surrounding logic (requesters plus datapath)
// ----------------------------------------------------------------------------
interface fpu_addsub_sched_if;
   import fpu_pkg::*;

   logic [NUM_PORTS-1:0]          req_valid;
   logic [NUM_PORTS-1:0]          req_ready;
   logic [NUM_PORTS-1:0]          req_op;
   logic [NUM_PORTS*FP_WIDTH-1:0] req_a;
   logic [NUM_PORTS*FP_WIDTH-1:0] req_b;

   logic [NUM_PORTS-1:0]          resp_valid;
   logic [NUM_PORTS-1:0]          resp_ready;
   logic [NUM_PORTS*FP_WIDTH-1:0] resp_result;
   logic [NUM_PORTS-1:0]          resp_ovf;
   logic [NUM_PORTS-1:0]          resp_unf;

   logic                          dp_valid;
   logic                          dp_op;
   logic [FP_WIDTH-1:0]           dp_a;
   logic [FP_WIDTH-1:0]           dp_b;
   logic [FP_WIDTH-1:0]           dp_result;
   logic                          dp_ovf;
   logic                          dp_unf;

`ifdef FPU_SCHED_EXC_STICKY_EN
   logic [1:0]                    exc_sticky;
   logic                          exc_clear;

   modport slave (
      input  req_valid, req_op, req_a, req_b, resp_ready,
      input  dp_result, dp_ovf, dp_unf, exc_clear,
      output req_ready, resp_valid, resp_result, resp_ovf, resp_unf,
      output dp_valid, dp_op, dp_a, dp_b, exc_sticky
   );

   modport master (
      output req_valid, req_op, req_a, req_b, resp_ready,
      output dp_result, dp_ovf, dp_unf, exc_clear,
      input  req_ready, resp_valid, resp_result, resp_ovf, resp_unf,
      input  dp_valid, dp_op, dp_a, dp_b, exc_sticky
   );
`else
   modport slave (
      input  req_valid, req_op, req_a, req_b, resp_ready,
      input  dp_result, dp_ovf, dp_unf,
      output req_ready, resp_valid, resp_result, resp_ovf, resp_unf,
      output dp_valid, dp_op, dp_a, dp_b
   );

   modport master (
      output req_valid, req_op, req_a, req_b, resp_ready,
      output dp_result, dp_ovf, dp_unf,
      input  req_ready, resp_valid, resp_result, resp_ovf, resp_unf,
      input  dp_valid, dp_op, dp_a, dp_b
   );
`endif

endinterface

// File: rtl/fpu_rr_arbiter.sv
// ----------------------------------------------------------------------------
// fpu_rr_arbiter
// Two-way round-robin arbiter with a 1-bit "last granted" pointer.
//   clk, rst      : clock, asynchronous active-high reset
//   eligible_i    : per-port eligibility (request valid and port not busy)
//   grant_o       : one-hot grant (all zero when nobody is eligible)
//   grant_tag_o   : index of the granted port
//   grant_any_o   : a grant is issued this cycle
// The pointer resets to 1 so that port 0 wins the first contested cycle.
// Every grant is an accept, because only eligible (valid) ports are granted.
// ----------------------------------------------------------------------------
module fpu_rr_arbiter
   import fpu_pkg::*;
(
   input  logic                 clk,
   input  logic                 rst,
   input  logic [NUM_PORTS-1:0] eligible_i,
   output logic [NUM_PORTS-1:0] grant_o,
   output port_tag_t            grant_tag_o,
   output logic                 grant_any_o
);

   port_tag_t last_q;
   port_tag_t last_d;

   always_comb begin
      grant_o = '0;
      case (eligible_i)
         2'b01:   grant_o = 2'b01;
         2'b10:   grant_o = 2'b10;
         // Contested: the port that did not win last time goes first.
         2'b11:   grant_o = last_q ? 2'b01 : 2'b10;
         default: grant_o = 2'b00;
      endcase
      grant_any_o = |grant_o;
      grant_tag_o = grant_to_tag(grant_o);
      last_d      = grant_any_o ? grant_tag_o : last_q;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         last_q <= 1'b1;
      end else begin
         last_q <= last_d;
      end
   end

endmodule

// File: rtl/fpu_addsub_sched.sv
// ----------------------------------------------------------------------------
// fpu_addsub_sched
// Shares one double-precision add/subtract datapath between two requesters.
// Requests are arbitrated round-robin, registered into an issue register that
// drives the datapath, tracked through its fixed latency and returned to the
// originating port with the datapath's overflow/underflow flags.
//   clk, rst    : clock, asynchronous active-high reset
//   bus (slave) : request, response and datapath signals, see
//                 fpu_addsub_sched_if
// Parameters:
//   DP_LATENCY  : cycles from dp_valid to dp_result (0 = combinational)
// Optional feature (macro FPU_SCHED_EXC_STICKY_EN): bus.exc_sticky collects
// {unf, ovf} of every captured result until bus.exc_clear; a flag arriving in
// the clearing cycle survives the clear.
// ----------------------------------------------------------------------------
module fpu_addsub_sched
   import fpu_pkg::*;
#(
   parameter int DP_LATENCY = 0
) (
   input  logic               clk,
   input  logic               rst,
   fpu_addsub_sched_if.slave  bus
);

   // ------------------------------------------------------------------
   // Arbitration
   // ------------------------------------------------------------------
   logic [NUM_PORTS-1:0] busy_all;
   logic [NUM_PORTS-1:0] eligible;
   logic [NUM_PORTS-1:0] grant;
   port_tag_t            grant_tag;
   logic                 grant_any;

   assign eligible = bus.req_valid & ~busy_all;

   fpu_rr_arbiter u_arb (
      .clk         (clk),
      .rst         (rst),
      .eligible_i  (eligible),
      .grant_o     (grant),
      .grant_tag_o (grant_tag),
      .grant_any_o (grant_any)
   );

   // req_ready is the grant itself, so it follows req_valid combinationally.
   assign bus.req_ready = grant;

   // ------------------------------------------------------------------
   // Issue register
   // ------------------------------------------------------------------
   logic [FP_WIDTH-1:0] req_a_port [NUM_PORTS];
   logic [FP_WIDTH-1:0] req_b_port [NUM_PORTS];

   genvar gi;
   generate
      for (gi = 0; gi < NUM_PORTS; gi++) begin : g_unpack
         assign req_a_port[gi] = bus.req_a[gi*FP_WIDTH +: FP_WIDTH];
         assign req_b_port[gi] = bus.req_b[gi*FP_WIDTH +: FP_WIDTH];
      end
   endgenerate

   issue_t issue_q;
   issue_t issue_d;
   logic   dp_valid_q;
   logic   dp_valid_d;

   always_comb begin
      issue_d    = issue_q;
      dp_valid_d = grant_any;
      if (grant_any) begin
         issue_d.op  = bus.req_op[grant_tag];
         issue_d.tag = grant_tag;
         issue_d.a   = req_a_port[grant_tag];
         issue_d.b   = req_b_port[grant_tag];
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         issue_q    <= '0;
         dp_valid_q <= 1'b0;
      end else begin
         issue_q    <= issue_d;
         dp_valid_q <= dp_valid_d;
      end
   end

   assign bus.dp_valid = dp_valid_q;
   assign bus.dp_op    = issue_q.op;
   assign bus.dp_a     = issue_q.a;
   assign bus.dp_b     = issue_q.b;

   // ------------------------------------------------------------------
   // Latency tracker: {valid, tag} travels alongside the datapath so the
   // result can be steered to its owner when it appears.
   // ------------------------------------------------------------------
   logic      emerge_valid;
   port_tag_t emerge_tag;

   generate
      if (DP_LATENCY == 0) begin : g_trk_comb
         assign emerge_valid = dp_valid_q;
         assign emerge_tag   = issue_q.tag;
      end else begin : g_trk_pipe
         logic      [DP_LATENCY-1:0] trk_valid_q;
         port_tag_t                  trk_tag_q [DP_LATENCY];

         always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
               // Clearing the valids is what makes results still inside the
               // datapath at reset time invisible afterwards.
               trk_valid_q <= '0;
               for (int k = 0; k < DP_LATENCY; k++) begin
                  trk_tag_q[k] <= 1'b0;
               end
            end else begin
               trk_valid_q[0] <= dp_valid_q;
               trk_tag_q[0]   <= issue_q.tag;
               for (int k = 1; k < DP_LATENCY; k++) begin
                  trk_valid_q[k] <= trk_valid_q[k-1];
                  trk_tag_q[k]   <= trk_tag_q[k-1];
               end
            end
         end

         assign emerge_valid = trk_valid_q[DP_LATENCY-1];
         assign emerge_tag   = trk_tag_q[DP_LATENCY-1];
      end
   endgenerate

   // ------------------------------------------------------------------
   // Per-port busy flag and response register. A port stays busy until its
   // response is taken, so a held response can never be overwritten and the
   // datapath never needs to stall.
   // ------------------------------------------------------------------
   logic [NUM_PORTS-1:0]          resp_valid_all;
   logic [NUM_PORTS-1:0]          resp_ovf_all;
   logic [NUM_PORTS-1:0]          resp_unf_all;
   logic [NUM_PORTS*FP_WIDTH-1:0] resp_result_all;

   generate
      for (gi = 0; gi < NUM_PORTS; gi++) begin : g_port
         logic                capture;
         logic                handshake;
         logic                busy_q,       busy_d;
         logic                resp_valid_q, resp_valid_d;
         logic [FP_WIDTH-1:0] result_q,     result_d;
         logic                ovf_q,        ovf_d;
         logic                unf_q,        unf_d;

         assign capture   = emerge_valid && (emerge_tag == port_tag_t'(gi));
         assign handshake = resp_valid_q & bus.resp_ready[gi];

         always_comb begin
            busy_d       = busy_q;
            resp_valid_d = resp_valid_q;
            result_d     = result_q;
            ovf_d        = ovf_q;
            unf_d        = unf_q;
            // Grant needs !busy and a handshake needs busy, so at most one
            // of these fires in a given cycle.
            if (grant[gi]) begin
               busy_d = 1'b1;
            end else if (handshake) begin
               busy_d = 1'b0;
            end
            if (capture) begin
               resp_valid_d = 1'b1;
               result_d     = bus.dp_result;
               ovf_d        = bus.dp_ovf;
               unf_d        = bus.dp_unf;
            end else if (handshake) begin
               resp_valid_d = 1'b0;
            end
         end

         always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
               busy_q       <= 1'b0;
               resp_valid_q <= 1'b0;
               result_q     <= '0;
               ovf_q        <= 1'b0;
               unf_q        <= 1'b0;
            end else begin
               busy_q       <= busy_d;
               resp_valid_q <= resp_valid_d;
               result_q     <= result_d;
               ovf_q        <= ovf_d;
               unf_q        <= unf_d;
            end
         end

         assign busy_all[gi]                                = busy_q;
         assign resp_valid_all[gi]                          = resp_valid_q;
         assign resp_ovf_all[gi]                            = ovf_q;
         assign resp_unf_all[gi]                            = unf_q;
         assign resp_result_all[gi*FP_WIDTH +: FP_WIDTH]    = result_q;
      end
   endgenerate

   assign bus.resp_valid  = resp_valid_all;
   assign bus.resp_ovf    = resp_ovf_all;
   assign bus.resp_unf    = resp_unf_all;
   assign bus.resp_result = resp_result_all;

   // ------------------------------------------------------------------
   // Sticky exception flags
   // ------------------------------------------------------------------
`ifdef FPU_SCHED_EXC_STICKY_EN
   logic [1:0] exc_sticky_q;
   logic [1:0] exc_sticky_d;

   always_comb begin
      exc_sticky_d = bus.exc_clear ? 2'b00 : exc_sticky_q;
      // Applied after the clear so a same-cycle flag is not lost.
      if (emerge_valid) begin
         exc_sticky_d = exc_sticky_d | {bus.dp_unf, bus.dp_ovf};
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         exc_sticky_q <= 2'b00;
      end else begin
         exc_sticky_q <= exc_sticky_d;
      end
   end

   assign bus.exc_sticky = exc_sticky_q;
`endif

endmodule

// File: doc/fpu_addsub_sched.md
# fpu_addsub_sched

Scheduler that shares one double-precision add/subtract datapath between two requesters. It accepts operations over per-port valid/ready handshakes and arbitrates round-robin. It issues registered operands to the datapath, tracks in-flight operations through the datapath's fixed latency, and returns each result with its overflow/underflow flags to the originating port. It sits between the FPU issue logic and the shared `fpu_dp_add`/`fpu_dp_sub` datapath pair.

## Interface
Parameters:
- `DP_LATENCY`, default 0: datapath latency in cycles from `dp_valid` to `dp_result` (0 = combinational).

Ports:
- `clk` in 1: single clock, rising edge.
- `rst` in 1: reset, asynchronous, active-high.
- `req_valid` in 2: per-port request valid; bit i is port i.
- `req_ready` out 2: per-port request accept.
- `req_op` in 2: per-port op; 0 = add, 1 = subtract (a − b).
- `req_a` in 128: operand a; bits [64i+63:64i] belong to port i.
- `req_b` in 128: operand b, same packing as `req_a`.
- `resp_valid` out 2: per-port response valid.
- `resp_ready` in 2: per-port response accept.
- `resp_result` out 128: per-port IEEE-754 double result, packed like `req_a`.
- `resp_ovf` out 2: per-port overflow flag.
- `resp_unf` out 2: per-port underflow flag.
- `dp_valid` out 1: operands on `dp_*` are valid this cycle.
- `dp_op` out 1: selects the add (0) or subtract (1) datapath.
- `dp_a` out 64: operand a to the datapath.
- `dp_b` out 64: operand b to the datapath.
- `dp_result` in 64: datapath result.
- `dp_ovf` in 1: datapath overflow flag.
- `dp_unf` in 1: datapath underflow flag.
- `exc_sticky` out 2: {unf, ovf} sticky flags; present only with the macro (see Configuration).
- `exc_clear` in 1: clears `exc_sticky`; present only with the macro.

## Operation
- Per-port `busy[i]` flag: set on accept, cleared on the response handshake (`resp_valid[i] & resp_ready[i]`). Each port has at most one operation outstanding.
- Eligible port: `req_valid[i] & !busy[i]`.
- Round-robin arbitration uses a 1-bit `last` pointer. With both ports eligible, grant goes to port `!last`; with one eligible, grant goes to that port.
- `last` updates to the granted port on accept.
- `req_ready[i]` = grant[i]. It depends combinationally on `req_valid`; requesters must not make `req_valid` depend on `req_ready`.
- At most one accept per cycle.
- Accept captures a, b, op and the port tag into the issue register.
- A `DP_LATENCY`-deep shift register carries {valid, tag} alongside the datapath.
- When the tracked valid emerges, `dp_result`, `dp_ovf` and `dp_unf` load into `resp_*[tag]`, and `resp_valid[tag]` is set.
- `resp_valid[i]` holds with stable data until `resp_ready[i]` is asserted.
- Because each port is busy until its response is taken, a response register is never overwritten; no backpressure reaches the datapath.
- No arithmetic in this block; operands pass unchanged.

## Timing
- Reset values:
  - `req_ready`, `resp_valid`, `dp_valid`, `busy` = 0.
  - `last` = 1, so port 0 wins first.
  - `dp_a`, `dp_b`, `dp_op`, `resp_result`, `resp_ovf`, `resp_unf` = 0.
  - `exc_sticky` = 0.
- Accept in cycle N gives `dp_valid` in cycle N+1. The result is sampled at N+1+`DP_LATENCY`. `resp_valid` rises at N+2+`DP_LATENCY`.
- Throughput: one issue per cycle across both ports; per port, one operation per round trip.
- Response handshake and a new request on the same port in the same cycle: `busy` clears at the clock edge, so the new request is accepted in the next cycle (no same-cycle reuse).
- Asserting `rst` mid-operation drops all in-flight and held results immediately. Datapath outputs arriving after reset are ignored, because the tracked valids are cleared.
- `exc_clear` and a new flag in the same cycle: the new flag wins (set after clear).

## Configuration
- `FPU_SCHED_EXC_STICKY_EN` defined:
  - Adds `exc_sticky`/`exc_clear`.
  - `exc_sticky` ORs in `dp_ovf`/`dp_unf` for every captured result.
  - `exc_clear` zeroes it, subject to the same-cycle rule in Timing.
- Undefined: ports and register are absent; behaviour is otherwise identical.

## Structure
- Shared `fpu_pkg`:
  - `FP_WIDTH` = 64.
  - Op encoding constants `FPU_OP_ADD` = 0, `FPU_OP_SUB` = 1.
  - Port-tag typedef (1 bit).
- One sub-module: `fpu_rr_arbiter`, a 2-way round-robin with `last` pointer and grant output. The latency tracker and response registers stay in the top.

## Test plan
- Port 0: add, a = 0x3FF0000000000000 (1.0), b = 0x4000000000000000 (2.0), `DP_LATENCY` = 2 -> `dp_valid` 1 cycle after accept; `resp_valid[0]` 4 cycles after accept; result 0x4008000000000000 (3.0); flags 0.
- Both ports valid every cycle, responses taken immediately -> grants alternate 0,1,0,1; port 0 first after reset.
- Port 1: subtract, 3.0 − 1.0, `resp_ready[1]` held low 10 cycles -> `resp_result[1]` = 0x4000000000000000 held stable; `req_ready[1]` = 0 throughout; port 0 keeps being served.
- Add 0x7FE0000000000000 + 0x7FE0000000000000 -> `resp_ovf` = 1 and, with `FPU_SCHED_EXC_STICKY_EN`, `exc_sticky[0]` = 1 until `exc_clear`; clear and a new overflow in the same cycle -> remains 1.
- `rst` asserted while 2 operations are in flight (`DP_LATENCY` = 3) -> no `resp_valid` ever; all outputs at reset values; next request completes normally.
- Response handshake on port 0 with a new `req_valid[0]` in the same cycle -> accepted exactly one cycle later.
